// File: rtl/ex_mem_stage.sv
// Execute stage (forwarding, ALU, branch/jump resolve) plus EX/MEM register and syscall halt FSM.
// Latency: 1 cycle to mem_*, redirect is same-cycle; stall holds the register and FSM and suppresses redirect.
module ex_mem_stage #(
  parameter logic [31:0] HALT_CODE    = 32'd10,
  parameter int          DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        go,
  input  logic        ex_status,
  input  logic        ex_bltz,
  input  logic        ex_beq,
  input  logic        ex_bne,
  input  logic        ex_jmp,
  input  logic        ex_jr,
  input  logic        ex_jal,
  input  logic        ex_syscall,
  input  logic        ex_sh,
  input  logic        ex_memtoreg,
  input  logic        ex_memwrite,
  input  logic        ex_regwrite,
  input  logic        ex_alusrcb,
  input  logic [3:0]  ex_aluop,
  input  logic [1:0]  ex_forward1,
  input  logic [1:0]  ex_forward2,
  input  logic [31:0] ex_r1,
  input  logic [31:0] ex_r2,
  input  logic [31:0] ex_imm16,
  input  logic [31:0] ex_imm26,
  input  logic [31:0] ex_pcand4,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_shamt,
  input  logic [4:0]  ex_writereg,
  input  logic [31:0] wb_data,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic [31:0] mem_result,
  output logic [31:0] mem_r2,
  output logic [31:0] mem_pc,
  output logic [4:0]  mem_writereg,
  output logic        mem_regwrite,
  output logic        mem_memtoreg,
  output logic        mem_memwrite,
  output logic        mem_sh,
  output logic        mem_status,
  output logic        halted,
  output logic [31:0] cnt_instr,
  output logic [31:0] cnt_taken
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t      state, next_state;
  logic [7:0]  drain_cnt, next_drain_cnt;
  logic [31:0] x, yr, y, alu, result;
  logic        taken, jump, halt_trig, valid_ld;

  logic unused_bits;
  assign unused_bits = ^ex_imm26[31:26];

  always_comb begin
    unique case (ex_forward1)
      2'b01:   x = mem_result;
      2'b10:   x = wb_data;
      default: x = ex_r1;
    endcase
    unique case (ex_forward2)
      2'b01:   yr = mem_result;
      2'b10:   yr = wb_data;
      default: yr = ex_r2;
    endcase
    y = ex_alusrcb ? ex_imm16 : yr;
  end

  always_comb begin
    alu = 32'd0;
    case (ex_aluop)
      4'd0:    alu = y << ex_shamt;
      4'd1:    alu = $unsigned($signed(y) >>> ex_shamt);
      4'd2:    alu = y >> ex_shamt;
      4'd3:    alu = x * y;
      4'd5:    alu = x + y;
      4'd6:    alu = x - y;
      4'd7:    alu = x & y;
      4'd8:    alu = x | y;
      4'd9:    alu = x ^ y;
      4'd10:   alu = ~(x | y);
      4'd11:   alu = {31'd0, $signed(x) < $signed(y)};
      4'd12:   alu = {31'd0, x < y};
      default: alu = 32'd0;
    endcase
    result = ex_jal ? ex_pcand4 : alu;
  end

  assign taken = ex_status && ((ex_beq && x == yr) || (ex_bne && x != yr) || (ex_bltz && x[31]));
  assign jump  = ex_status && (ex_jmp || ex_jal || ex_jr);

  always_comb begin
    if (ex_jr)
      redirect_pc = x;
    else if (ex_jmp || ex_jal)
      redirect_pc = {ex_pcand4[31:28], ex_imm26[25:0], 2'b00};
    else
      redirect_pc = ex_pcand4 + (ex_imm16 << 2);
  end

  assign redirect  = (state == RUN) && !stall && (taken || jump);
  assign halt_trig = (state == RUN) && !stall && ex_status && ex_syscall && (x == HALT_CODE);
  // The halting syscall itself retires as a bubble, as does everything outside RUN.
  assign valid_ld  = (state == RUN) && !stall && ex_status && !halt_trig;
  assign halted    = (state == HALTED);

  always_comb begin
    next_state     = state;
    next_drain_cnt = drain_cnt;
    if (!stall) begin
      case (state)
        RUN: if (halt_trig) begin
          next_state     = DRAIN;
          next_drain_cnt = 8'd0;
        end
        DRAIN: begin
          next_drain_cnt = drain_cnt + 8'd1;
          if (drain_cnt == 8'(DRAIN_CYCLES - 1))
            next_state = HALTED;
        end
        HALTED: if (go) next_state = RUN;
        default: next_state = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= 8'd0;
    end else begin
      state     <= next_state;
      drain_cnt <= next_drain_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_result   <= 32'd0;
      mem_r2       <= 32'd0;
      mem_pc       <= 32'd0;
      mem_writereg <= 5'd0;
      mem_regwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_sh       <= 1'b0;
      mem_status   <= 1'b0;
      cnt_instr    <= 32'd0;
      cnt_taken    <= 32'd0;
    end else begin
      if (valid_ld) cnt_instr <= cnt_instr + 32'd1;
      if (redirect) cnt_taken <= cnt_taken + 32'd1;
      if (!stall) begin
        mem_result   <= result;
        mem_r2       <= yr;
        mem_pc       <= ex_pc;
        mem_writereg <= ex_writereg;
        mem_regwrite <= valid_ld && ex_regwrite;
        mem_memtoreg <= valid_ld && ex_memtoreg;
        mem_memwrite <= valid_ld && ex_memwrite;
        mem_sh       <= valid_ld && ex_sh;
        mem_status   <= valid_ld;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: hand-computed vectors checked with immediate assertions.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst, stall, go;
  logic        ex_status, ex_bltz, ex_beq, ex_bne, ex_jmp, ex_jr, ex_jal, ex_syscall;
  logic        ex_sh, ex_memtoreg, ex_memwrite, ex_regwrite, ex_alusrcb;
  logic [3:0]  ex_aluop;
  logic [1:0]  ex_forward1, ex_forward2;
  logic [31:0] ex_r1, ex_r2, ex_imm16, ex_imm26, ex_pcand4, ex_pc, wb_data;
  logic [4:0]  ex_shamt, ex_writereg;
  logic        redirect;
  logic [31:0] redirect_pc, mem_result, mem_r2, mem_pc;
  logic [4:0]  mem_writereg;
  logic        mem_regwrite, mem_memtoreg, mem_memwrite, mem_sh, mem_status, halted;
  logic [31:0] cnt_instr, cnt_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .go(go),
    .ex_status(ex_status), .ex_bltz(ex_bltz), .ex_beq(ex_beq), .ex_bne(ex_bne),
    .ex_jmp(ex_jmp), .ex_jr(ex_jr), .ex_jal(ex_jal), .ex_syscall(ex_syscall),
    .ex_sh(ex_sh), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
    .ex_regwrite(ex_regwrite), .ex_alusrcb(ex_alusrcb), .ex_aluop(ex_aluop),
    .ex_forward1(ex_forward1), .ex_forward2(ex_forward2),
    .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_imm16(ex_imm16), .ex_imm26(ex_imm26),
    .ex_pcand4(ex_pcand4), .ex_pc(ex_pc), .ex_shamt(ex_shamt), .ex_writereg(ex_writereg),
    .wb_data(wb_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_result(mem_result), .mem_r2(mem_r2), .mem_pc(mem_pc), .mem_writereg(mem_writereg),
    .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_memwrite(mem_memwrite),
    .mem_sh(mem_sh), .mem_status(mem_status), .halted(halted),
    .cnt_instr(cnt_instr), .cnt_taken(cnt_taken)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    {ex_status, ex_bltz, ex_beq, ex_bne, ex_jmp, ex_jr, ex_jal, ex_syscall} = '0;
    {ex_sh, ex_memtoreg, ex_memwrite, ex_regwrite, ex_alusrcb} = '0;
    ex_aluop = 4'd0; ex_forward1 = 2'b00; ex_forward2 = 2'b00;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; go = 1'b0;
    clear_ctl();
    ex_r1 = '0; ex_r2 = '0; ex_imm16 = '0; ex_imm26 = '0; ex_pcand4 = '0; ex_pc = '0;
    wb_data = '0; ex_shamt = '0; ex_writereg = '0;
    tick(); tick();
    check("rst_result", mem_result, 32'd0);
    check("rst_regwrite", {31'd0, mem_regwrite}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_cnt_instr", cnt_instr, 32'd0);
    check("rst_cnt_taken", cnt_taken, 32'd0);
    rst = 1'b1;

    // ADD 5 + 7
    ex_status = 1; ex_aluop = 4'd5; ex_regwrite = 1; ex_writereg = 5'd8;
    ex_r1 = 32'd5; ex_r2 = 32'd7;
    tick();
    check("add_result", mem_result, 32'd12);
    check("add_writereg", {27'd0, mem_writereg}, 32'd8);
    check("add_regwrite", {31'd0, mem_regwrite}, 32'd1);
    check("add_cnt_instr", cnt_instr, 32'd1);

    // forward EX/MEM result (12) and wb_data (3)
    ex_r1 = 32'd0; ex_r2 = 32'd0; ex_forward1 = 2'b01; ex_forward2 = 2'b10; wb_data = 32'd3;
    tick();
    check("fwd_result", mem_result, 32'd15);
    check("fwd_r2", mem_r2, 32'd3);
    check("fwd_cnt_instr", cnt_instr, 32'd2);

    // invalid instruction loads as bubble
    ex_forward1 = 2'b00; ex_forward2 = 2'b00; ex_status = 0;
    tick();
    check("bub_regwrite", {31'd0, mem_regwrite}, 32'd0);
    check("bub_status", {31'd0, mem_status}, 32'd0);
    check("bub_cnt_instr", cnt_instr, 32'd2);

    // BNE taken, first under stall
    clear_ctl();
    ex_status = 1; ex_bne = 1; ex_r1 = 32'd1; ex_r2 = 32'd2;
    ex_pcand4 = 32'h100; ex_imm16 = 32'hFFFF_FFFF; stall = 1;
    #1;
    check("bne_stall_redirect", {31'd0, redirect}, 32'd0);
    tick();
    check("bne_stall_cnt_taken", cnt_taken, 32'd0);
    check("bne_stall_cnt_instr", cnt_instr, 32'd2);
    stall = 0;
    #1;
    check("bne_redirect", {31'd0, redirect}, 32'd1);
    check("bne_target", redirect_pc, 32'h0000_00FC);
    tick();
    check("bne_cnt_taken", cnt_taken, 32'd1);
    ex_r2 = 32'd1;
    #1;
    check("bne_equal_redirect", {31'd0, redirect}, 32'd0);
    tick();

    // JAL
    ex_bne = 0; ex_jal = 1; ex_imm26 = 32'h40; ex_pcand4 = 32'h0040_0008;
    ex_regwrite = 1; ex_writereg = 5'd31;
    #1;
    check("jal_redirect", {31'd0, redirect}, 32'd1);
    check("jal_target", redirect_pc, 32'h0000_0100);
    tick();
    check("jal_result", mem_result, 32'h0040_0008);
    check("jal_cnt_taken", cnt_taken, 32'd2);
    check("jal_cnt_instr", cnt_instr, 32'd5);

    // SUB 0 - 1, SRA 0x80000000 by 4
    ex_jal = 0; ex_aluop = 4'd6; ex_r1 = 32'd0; ex_r2 = 32'd1;
    tick();
    check("sub_wrap", mem_result, 32'hFFFF_FFFF);
    ex_aluop = 4'd1; ex_r2 = 32'h8000_0000; ex_shamt = 5'd4;
    tick();
    check("sra", mem_result, 32'hF800_0000);

    // syscall with X = 4 is a no-op
    ex_aluop = 4'd5; ex_regwrite = 0; ex_syscall = 1; ex_r1 = 32'd4; ex_r2 = 32'd0;
    tick();
    check("sys4_halted", {31'd0, halted}, 32'd0);
    check("sys4_status", {31'd0, mem_status}, 32'd1);
    check("sys4_cnt_instr", cnt_instr, 32'd8);

    // exit syscall: bubble, two drain bubbles, then halted
    ex_r1 = 32'd10;
    tick();
    check("sys10_status", {31'd0, mem_status}, 32'd0);
    check("sys10_halted", {31'd0, halted}, 32'd0);
    ex_syscall = 0; ex_regwrite = 1; ex_r1 = 32'd1;
    tick();
    check("drain1_status", {31'd0, mem_status}, 32'd0);
    check("drain1_halted", {31'd0, halted}, 32'd0);
    tick();
    check("drain2_status", {31'd0, mem_status}, 32'd0);
    check("drain2_halted", {31'd0, halted}, 32'd1);
    check("drain_cnt_instr", cnt_instr, 32'd8);
    ex_jmp = 1;
    #1;
    check("halted_redirect", {31'd0, redirect}, 32'd0);
    tick();
    check("halted_hold", {31'd0, halted}, 32'd1);
    ex_jmp = 0; go = 1;
    tick();
    check("go_halted", {31'd0, halted}, 32'd0);
    go = 0;
    tick();
    check("resume_status", {31'd0, mem_status}, 32'd1);
    check("resume_cnt_instr", cnt_instr, 32'd9);

    // reset in the middle of DRAIN
    ex_syscall = 1; ex_r1 = 32'd10;
    tick();
    ex_syscall = 0; ex_r1 = 32'd5; ex_r2 = 32'd7; rst = 0; go = 1; stall = 1;
    tick();
    check("rstd_halted", {31'd0, halted}, 32'd0);
    check("rstd_status", {31'd0, mem_status}, 32'd0);
    check("rstd_result", mem_result, 32'd0);
    check("rstd_cnt_instr", cnt_instr, 32'd0);
    check("rstd_cnt_taken", cnt_taken, 32'd0);
    rst = 1; go = 0; stall = 0;
    tick();
    check("post_rst_result", mem_result, 32'd12);
    check("post_rst_status", {31'd0, mem_status}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
